// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchronizer, 3-sample majority vote per bit, receive FIFO.
// Optional feature macro UART_RX_BREAK_DET_EN: report line breaks on break_det instead of pushing them.
module uart_rx_os #(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sample_tick,
    input  logic                        rx,
    input  logic [1:0]                  cfg_data_bits,
    input  logic                        cfg_parity_en,
    input  logic                        cfg_parity_odd,
    input  logic                        cfg_two_stop,
    input  logic                        rd_en,
    output logic [7:0]                  rd_data,
    output logic                        rd_perr,
    output logic                        rd_ferr,
    output logic                        rd_valid,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        rx_busy,
    output logic                        overrun,
    input  logic                        clr_overrun,
    output logic                        break_det
);
    localparam int CW = $clog2(OVERSAMPLE + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam logic [CW-1:0] HALF_C  = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] OS_C    = CW'(OVERSAMPLE);
    localparam logic [CW-1:0] OSM1_C  = CW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] DEPTH_C = NW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t        state_q, state_d;
    logic          rx_s1_q, rx_s2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    sh_q, sh_d;
    logic [1:0]    smp_q, smp_d;
    logic          perr_q, perr_d, ferr_q, ferr_d, low_q, low_d, brk_q, brk_d;
    logic [1:0]    cfg_bits_q, cfg_bits_d;
    logic          par_en_q, par_en_d, par_odd_q, par_odd_d, two_stop_q, two_stop_d;
    logic          overrun_q, overrun_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0] count_q, count_d;
    logic [9:0]    mem_q [FIFO_DEPTH];

    logic          rx_s, vote, do_vote, ferr_nxt, low_nxt, push, pop, full, wr_en;
    logic [1:0]    shamt;
    logic [7:0]    word;
    logic [9:0]    push_word, head;

    assign rx_s = rx_s2_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        sh_d       = sh_q;
        smp_d      = smp_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        low_d      = low_q;
        brk_d      = 1'b0;
        cfg_bits_d = cfg_bits_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        two_stop_d = two_stop_q;
        push       = 1'b0;
        do_vote    = 1'b0;
        shamt      = 2'd3 - cfg_bits_q;
        word       = sh_q >> shamt;
        vote       = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_s) | (smp_q[0] & rx_s);
        ferr_nxt   = ferr_q | ~vote;
        low_nxt    = low_q & ~vote;

        // Bit-period countdown: samples at 2 and 1, vote at 0, lands at ticks HALF-1/HALF/HALF+1.
        if (sample_tick && (state_q == DATA || state_q == PARITY || state_q == STOP)) begin
            if (cnt_q == CW'(2)) smp_d[1] = rx_s;
            if (cnt_q == CW'(1)) smp_d[0] = rx_s;
            if (cnt_q == '0) begin
                do_vote = 1'b1;
                cnt_d   = OSM1_C;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (sample_tick && !rx_s) begin
                    state_d    = START;
                    cnt_d      = '0;
                    cfg_bits_d = cfg_data_bits;
                    par_en_d   = cfg_parity_en;
                    par_odd_d  = cfg_parity_odd;
                    two_stop_d = cfg_two_stop;
                end
            end
            START: begin
                if (sample_tick) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == HALF_C) begin
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            // First data vote falls OVERSAMPLE+1 ticks after the start-bit centre.
                            state_d   = DATA;
                            cnt_d     = OS_C;
                            bit_cnt_d = 3'd0;
                            perr_d    = 1'b0;
                            ferr_d    = 1'b0;
                            low_d     = 1'b1;
                        end
                    end
                end
            end
            DATA: begin
                if (do_vote) begin
                    sh_d  = {vote, sh_q[7:1]};
                    low_d = low_nxt;
                    if (bit_cnt_q == 3'd4 + {1'b0, cfg_bits_q}) begin
                        bit_cnt_d = 3'd0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (do_vote) begin
                    perr_d  = vote ^ (^word) ^ par_odd_q;
                    low_d   = low_nxt;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (do_vote) begin
                    ferr_d = ferr_nxt;
                    low_d  = low_nxt;
                    if (two_stop_q && bit_cnt_q == 3'd0) begin
                        bit_cnt_d = 3'd1;
                    end else begin
`ifdef UART_RX_BREAK_DET_EN
                        if (low_nxt) begin
                            brk_d   = 1'b1;
                            state_d = WAIT_HIGH;
                        end else begin
                            push    = 1'b1;
                            state_d = vote ? IDLE : WAIT_HIGH;
                        end
`else
                        push    = 1'b1;
                        state_d = vote ? IDLE : WAIT_HIGH;
`endif
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        push_word = {word, perr_q, ferr_nxt};
    end

    // Full FIFO accepts a push only when a pop frees a slot in the same cycle.
    always_comb begin
        pop       = rd_en && (count_q != '0);
        full      = (count_q == DEPTH_C);
        wr_en     = push && (!full || pop);
        wr_ptr_d  = wr_ptr_q + AW'(wr_en);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        count_d   = count_q + NW'(wr_en) - NW'(pop);
        overrun_d = (push && full && !pop) ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            sh_q       <= '0;
            smp_q      <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            low_q      <= 1'b0;
            brk_q      <= 1'b0;
            cfg_bits_q <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            overrun_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sh_q       <= sh_d;
            smp_q      <= smp_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            low_q      <= low_d;
            brk_q      <= brk_d;
            cfg_bits_q <= cfg_bits_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            two_stop_q <= two_stop_d;
            overrun_q  <= overrun_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_word;
    end

    assign head       = mem_q[rd_ptr_q];
    assign rd_valid   = (count_q != '0);
    assign rd_data    = rd_valid ? head[9:2] : 8'h00;
    assign rd_perr    = rd_valid & head[1];
    assign rd_ferr    = rd_valid & head[0];
    assign fifo_count = count_q;
    assign rx_busy    = (state_q != IDLE);
    assign overrun    = overrun_q;
    assign break_det  = brk_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Testbench for uart_rx_os: directed frames plus randomized frames checked against a queue model.
module tb_uart_rx_os;
    localparam int OS        = 16;
    localparam int DEPTH     = 8;
    localparam int TICK_DIV  = 4;
    localparam int BIT_CLKS  = OS * TICK_DIV;

    logic       clk, rst_n, sample_tick, rx;
    logic [1:0] cfg_data_bits;
    logic       cfg_parity_en, cfg_parity_odd, cfg_two_stop, rd_en, clr_overrun;
    logic [7:0] rd_data;
    logic       rd_perr, rd_ferr, rd_valid, rx_busy, overrun, break_det;
    logic [$clog2(DEPTH):0] fifo_count;

    uart_rx_os #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rx(rx),
        .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd), .cfg_two_stop(cfg_two_stop),
        .rd_en(rd_en), .rd_data(rd_data), .rd_perr(rd_perr), .rd_ferr(rd_ferr),
        .rd_valid(rd_valid), .fifo_count(fifo_count), .rx_busy(rx_busy),
        .overrun(overrun), .clr_overrun(clr_overrun), .break_det(break_det)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] div = 2'd0;
    initial sample_tick = 1'b0;
    always @(posedge clk) begin
        div         <= div + 2'd1;
        sample_tick <= (div == 2'd3);
    end

    int brk_cnt = 0;
    always @(posedge clk) if (break_det) brk_cnt <= brk_cnt + 1;

    typedef struct { logic [7:0] d; logic p; logic f; } ent_t;
    ent_t exp_q[$];
    bit   model_ovr = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_push(input ent_t e);
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else model_ovr = 1'b1;
    endfunction

    // Expected entry from frame contents: word masked to its length, flags from what was sent.
    function automatic ent_t frame_result(input logic [7:0] data, input logic [1:0] code,
                                          input bit pen, input bit bad_par, input bit bad_stop);
        ent_t e;
        e.d = 8'h00;
        for (int i = 0; i < 5 + int'(code); i++) e.d[i] = data[i];
        e.p = pen && bad_par;
        e.f = bad_stop;
        return e;
    endfunction

    task automatic drive_bit(input logic val, input bit glitch);
        for (int i = 0; i < BIT_CLKS; i++) begin
            @(negedge clk);
            rx = (glitch && i >= 30 && i < 34) ? ~val : val;
        end
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic [1:0] code, input bit pen,
                              input bit odd, input bit two, input bit bad_par,
                              input bit bad_stop, input int glitch_bit, input bit scramble);
        logic b[$];
        int   n;
        int   ones;
        n    = 5 + int'(code);
        ones = 0;
        b.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            b.push_back(data[i]);
            if (data[i]) ones++;
        end
        if (pen) b.push_back(logic'(((ones + (odd ? 1 : 0)) % 2 == 1) ^ bad_par));
        b.push_back(~bad_stop);
        if (two) b.push_back(~bad_stop);
        cfg_data_bits = code; cfg_parity_en = pen; cfg_parity_odd = odd; cfg_two_stop = two;
        for (int i = 0; i < b.size(); i++) begin
            drive_bit(b[i], i == glitch_bit);
            if (i == 0 && scramble) begin
                cfg_data_bits  = 2'($urandom_range(0, 3));
                cfg_parity_en  = 1'($urandom_range(0, 1));
                cfg_parity_odd = 1'($urandom_range(0, 1));
                cfg_two_stop   = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic pop_one();
        @(negedge clk) rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        ent_t e;
        chk({tag, "_count"}, 32'(fifo_count), 32'(exp_q.size()));
        chk({tag, "_overrun"}, 32'(overrun), 32'(model_ovr));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
            chk({tag, "_data"}, 32'(rd_data), 32'(e.d));
            chk({tag, "_perr"}, 32'(rd_perr), 32'(e.p));
            chk({tag, "_ferr"}, 32'(rd_ferr), 32'(e.f));
            pop_one();
        end
        chk({tag, "_empty"}, 32'(rd_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] code;
        bit         pen, odd, two, bpar, bstop;
        int         burst, g;

        rst_n = 1'b0; rx = 1'b1; rd_en = 1'b0; clr_overrun = 1'b0;
        cfg_data_bits = 2'b11; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_two_stop = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_rd_perr", 32'(rd_perr), 32'd0);
        chk("rst_rd_ferr", 32'(rd_ferr), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_rx_busy", 32'(rx_busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_break_det", 32'(break_det), 32'd0);
        rst_n = 1'b1;
        idle_bits(1);

        // 8N1 0xA5 with push timing around the stop-bit centre
        fork
            send_frame(8'hA5, 2'b11, 0, 0, 0, 0, 0, -1, 0);
            begin
                repeat (9 * BIT_CLKS + 16) @(negedge clk);
                chk("a5_valid_before_vote", 32'(rd_valid), 32'd0);
                repeat (40) @(negedge clk);
                chk("a5_valid_after_vote", 32'(rd_valid), 32'd1);
            end
        join
        model_push(frame_result(8'hA5, 2'b11, 0, 0, 0));
        idle_bits(1);
        drain_check("a5");
        pop_one();
        chk("pop_empty_count", 32'(fifo_count), 32'd0);

        // 7E1 0x35 wrong parity, then 5O2 0x1F
        send_frame(8'h35, 2'b10, 1, 0, 0, 1, 0, -1, 0);
        model_push(frame_result(8'h35, 2'b10, 1, 1, 0));
        idle_bits(1);
        send_frame(8'h1F, 2'b00, 1, 1, 1, 0, 0, -1, 0);
        model_push(frame_result(8'h1F, 2'b00, 1, 0, 0));
        idle_bits(1);
        drain_check("par");

        // Short low pulse in IDLE is rejected
        @(negedge clk) rx = 1'b0;
        repeat (OS / 4 * TICK_DIV) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch_busy_high", 32'(rx_busy), 32'd1);
        repeat (20 * TICK_DIV) @(negedge clk);
        chk("glitch_busy_low", 32'(rx_busy), 32'd0);
        chk("glitch_no_entry", 32'(fifo_count), 32'd0);

        // One-tick glitch at a data bit centre
        send_frame(8'h5A, 2'b11, 0, 0, 0, 0, 0, 3, 0);
        model_push(frame_result(8'h5A, 2'b11, 0, 0, 0));
        idle_bits(1);
        drain_check("midglitch");

        // Overrun: nine words into an eight-deep FIFO
        for (int i = 0; i < 9; i++) begin
            d = 8'(8'h10 + 8'(i * 7));
            send_frame(d, 2'b11, 0, 0, 0, 0, 0, -1, 0);
            model_push(frame_result(d, 2'b11, 0, 0, 0));
            idle_bits(1);
        end
        chk("ovr_count", 32'(fifo_count), 32'(DEPTH));
        chk("ovr_flag", 32'(overrun), 32'(model_ovr));
        @(negedge clk) clr_overrun = 1'b1;
        @(negedge clk) clr_overrun = 1'b0;
        model_ovr = 1'b0;
        chk("ovr_cleared", 32'(overrun), 32'd0);
        drain_check("ovr");

        // Line break: rx low for two frame times
        cfg_data_bits = 2'b11; cfg_parity_en = 1'b0; cfg_two_stop = 1'b0;
        @(negedge clk) rx = 1'b0;
        repeat (20 * BIT_CLKS) @(negedge clk);
        chk("brk_busy_while_low", 32'(rx_busy), 32'd1);
`ifdef UART_RX_BREAK_DET_EN
        chk("brk_pulses", 32'(brk_cnt), 32'd1);
        chk("brk_fifo_empty", 32'(fifo_count), 32'd0);
`else
        chk("brk_pulses", 32'(brk_cnt), 32'd0);
        chk("brk_fifo_one", 32'(fifo_count), 32'd1);
        model_push('{d: 8'h00, p: 1'b0, f: 1'b1});
`endif
        idle_bits(1);
        chk("brk_idle_after_high", 32'(rx_busy), 32'd0);
        drain_check("brk");

        // Reset mid-DATA discards FIFO contents and the partial word
        send_frame(8'h77, 2'b11, 0, 0, 0, 0, 0, -1, 0);
        idle_bits(1);
        drive_bit(1'b0, 0);
        drive_bit(1'b1, 0);
        drive_bit(1'b0, 0);
        @(negedge clk) rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_busy", 32'(rx_busy), 32'd0);
        chk("midrst_count", 32'(fifo_count), 32'd0);
        rx = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        idle_bits(2);
        chk("postrst_count", 32'(fifo_count), 32'd0);
        send_frame(8'h3C, 2'b11, 0, 0, 0, 0, 0, -1, 0);
        model_push(frame_result(8'h3C, 2'b11, 0, 0, 0));
        idle_bits(1);
        drain_check("postrst");

        // Randomized bursts, cfg pins scrambled mid-frame
        for (int it = 0; it < 20; it++) begin
            burst = $urandom_range(1, 3);
            for (int k = 0; k < burst; k++) begin
                d     = 8'($urandom);
                code  = 2'($urandom_range(0, 3));
                pen   = 1'($urandom_range(0, 1));
                odd   = 1'($urandom_range(0, 1));
                two   = 1'($urandom_range(0, 1));
                bpar  = 1'($urandom_range(0, 3) == 0);
                bstop = 1'($urandom_range(0, 4) == 0);
                if (frame_result(d, code, 0, 0, 0).d == 8'h00) bstop = 1'b0;
                g = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : -1;
                send_frame(d, code, pen, odd, two, bpar, bstop, g, 1);
                model_push(frame_result(d, code, pen, bpar, bstop));
                idle_bits(1);
            end
            drain_check("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
